// File: rtl/ascii_dec_pkg.sv
// ascii_dec_pkg: shared types and constants for the ASCII command decoder.
//   - state_e       : parser/emitter FSM states
//   - CMD_READ/WRITE: default first byte of read/write packets
//   - ASCII_*       : character codes recognised by the parser
package ascii_dec_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSepA,
    StAddrLo,
    StSepD,
    StDataLo,
    StTail,
    StEmit,
    StErr
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'd48;
  localparam logic [7:0] CMD_WRITE = 8'd49;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_W_UP = 8'h57;
  localparam logic [7:0] ASCII_W_LO = 8'h77;

endpackage

// File: rtl/hex_nibble.sv
// hex_nibble: combinational ASCII hex digit decoder.
//   char_i   : ASCII character
//   value_o  : nibble value (0 when not a hex digit)
//   is_hex_o : character is 0-9, A-F or a-f
module hex_nibble (
  input  logic [7:0] char_i,
  output logic [3:0] value_o,
  output logic       is_hex_o
);

  always_comb begin
    value_o  = 4'd0;
    is_hex_o = 1'b0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      is_hex_o = 1'b1;
      value_o  = char_i[3:0];
    end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                 (char_i >= 8'h61 && char_i <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      is_hex_o = 1'b1;
      value_o  = char_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/ascii_cmd_decoder.sv
// ascii_cmd_decoder: parses typed command lines ("W aa dd" / "R aa", ended by CR or LF)
// into binary packets {CMD_WRITE, addr, data} or {CMD_READ, addr}.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_data    : ASCII character stream, accepted on in_valid & in_ready
//   in_ready            : low while a packet drains and during reset
//   out_valid/out_data  : packet byte stream, consumed on out_valid & out_ready
//   err                 : registered one-cycle pulse per malformed line
//   err_count           : saturating malformed-line count (only with ASCII_DEC_ERR_CNT_EN)
// Optional feature macro: ASCII_DEC_ERR_CNT_EN.
module ascii_cmd_decoder
  import ascii_dec_pkg::*;
#(
  parameter logic [7:0] CmdRead  = CMD_READ,
  parameter logic [7:0] CmdWrite = CMD_WRITE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
`ifdef ASCII_DEC_ERR_CNT_EN
  output logic [7:0] err_count,
`endif
  output logic       err
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       is_wr_q, is_wr_d;
  logic       sp_seen_q, sp_seen_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;

  logic [3:0] nib;
  logic       is_hex;
  logic       is_sp, is_term, is_rd_cmd, is_wr_cmd, accept;

  hex_nibble u_hex_nibble (
    .char_i   (in_data),
    .value_o  (nib),
    .is_hex_o (is_hex)
  );

  assign is_sp     = (in_data == ASCII_SP);
  assign is_term   = (in_data == ASCII_CR) || (in_data == ASCII_LF);
  assign is_rd_cmd = (in_data == ASCII_R_UP) || (in_data == ASCII_R_LO);
  assign is_wr_cmd = (in_data == ASCII_W_UP) || (in_data == ASCII_W_LO);

  assign in_ready = rst_n && (state_q != StEmit);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    is_wr_d   = is_wr_q;
    sp_seen_d = sp_seen_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept && !is_sp && !is_term) begin
          sp_seen_d = 1'b0;
          if (is_rd_cmd) begin
            is_wr_d = 1'b0;
            state_d = StSepA;
          end else if (is_wr_cmd) begin
            is_wr_d = 1'b1;
            state_d = StSepA;
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end

      StSepA, StSepD: begin
        if (accept) begin
          if (is_sp) begin
            sp_seen_d = 1'b1;
          end else if (is_term) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (is_hex && sp_seen_q) begin
            if (state_q == StSepA) begin
              addr_d[7:4] = nib;
              state_d     = StAddrLo;
            end else begin
              data_d[7:4] = nib;
              state_d     = StDataLo;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end

      StAddrLo, StDataLo: begin
        if (accept) begin
          if (is_hex) begin
            if (state_q == StAddrLo) begin
              addr_d[3:0] = nib;
              sp_seen_d   = 1'b0;
              state_d     = is_wr_q ? StSepD : StTail;
            end else begin
              data_d[3:0] = nib;
              state_d     = StTail;
            end
          end else if (is_term) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end

      StTail: begin
        if (accept && !is_sp) begin
          if (is_term) begin
            idx_d   = 2'd0;
            state_d = StEmit;
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end

      StEmit: begin
        if (out_ready) begin
          if (idx_q == (is_wr_q ? 2'd2 : 2'd1)) begin
            idx_d   = 2'd0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      StErr: begin
        // Swallow the rest of the malformed line; the err pulse already fired.
        if (accept && is_term) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      is_wr_q   <= 1'b0;
      sp_seen_q <= 1'b0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      is_wr_q   <= is_wr_d;
      sp_seen_q <= sp_seen_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  // Output byte is a pure function of registered state.
  always_comb begin
    out_valid = (state_q == StEmit);
    out_data  = 8'd0;
    if (state_q == StEmit) begin
      case (idx_q)
        2'd0:    out_data = is_wr_q ? CmdWrite : CmdRead;
        2'd1:    out_data = addr_q;
        default: out_data = data_q;
      endcase
    end
  end

  assign err = err_q;

`ifdef ASCII_DEC_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ascii_cmd_decoder.sv
// Self-checking bench for ascii_cmd_decoder: directed scenarios plus randomized
// command lines checked against a line-level reference model.
module tb_ascii_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       err;
`ifdef ASCII_DEC_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  ascii_cmd_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef ASCII_DEC_ERR_CNT_EN
    .err_count (err_count),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned got_q[$];
  byte unsigned exp_q[$];
  int           err_seen = 0;
  int           exp_err  = 0;
  int           exp_cnt  = 0;
  bit           bp_rand  = 1'b0;
  string        mbuf     = "";

  // Monitor: record completed output handshakes and err pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (err) err_seen++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic string str1(input byte unsigned b);
    string t;
    t = " ";
    t[0] = b;
    return t;
  endfunction

  function automatic bit is_hex_c(input byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic byte unsigned hex_val(input byte unsigned c);
    if (c <= "9") return c - 8'h30;
    return (c | 8'h20) - 8'h61 + 8'd10;
  endfunction

  // Judge one whole line (first non-blank char up to, excluding, the terminator).
  function automatic void eval_line(input string l);
    int           n;
    int           p;
    bit           ok;
    bit           wr;
    byte unsigned fld[2];
    n  = l.len();
    ok = 1'b1;
    wr = 1'b0;
    if (l[0] == "R" || l[0] == "r") wr = 1'b0;
    else if (l[0] == "W" || l[0] == "w") wr = 1'b1;
    else ok = 1'b0;
    p = 1;
    for (int f = 0; f < (wr ? 2 : 1); f++) begin
      int nsp = 0;
      if (ok) begin
        while (p < n && l[p] == " ") begin
          nsp++;
          p++;
        end
        if (nsp == 0 || p + 1 >= n || !is_hex_c(l[p]) || !is_hex_c(l[p+1])) begin
          ok = 1'b0;
        end else begin
          fld[f] = hex_val(l[p]) * 16 + hex_val(l[p+1]);
          p += 2;
        end
      end
    end
    while (ok && p < n) begin
      if (l[p] != " ") ok = 1'b0;
      p++;
    end
    if (ok) begin
      exp_q.push_back(wr ? 8'd49 : 8'd48);
      exp_q.push_back(fld[0]);
      if (wr) exp_q.push_back(fld[1]);
    end else begin
      exp_err++;
      if (exp_cnt < 255) exp_cnt++;
    end
  endfunction

  function automatic void model_feed(input byte unsigned c);
    bit term;
    term = (c == 8'h0D) || (c == 8'h0A);
    if (mbuf.len() == 0 && (term || c == " ")) return;
    if (term) begin
      eval_line(mbuf);
      mbuf = "";
    end else begin
      mbuf = {mbuf, str1(c)};
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send_line(input string s, input bit feed_model);
    for (int i = 0; i < s.len(); i++) begin
      bit taken = 1'b0;
      if (feed_model) model_feed(s[i]);
      in_valid = 1'b1;
      in_data  = s[i];
      for (int t = 0; t < 50 && !taken; t++) begin
        @(negedge clk);
        taken = in_ready;
        @(posedge clk);
        #1;
        if (bp_rand) out_ready = 1'($urandom_range(0, 1));
      end
      if (!taken) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_handshake: char %0d not accepted, in_ready stuck at %0b required 1",
                 i, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int t = 0; t < 80 && !idle; t++) begin
      @(negedge clk);
      idle = in_ready && !out_valid;
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    if (!idle) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: decoder did not return to idle, in_ready=%0b out_valid=%0b",
               in_ready, out_valid);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    err_seen = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%0b data=%0d required 0/0", out_valid, out_data);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %0b required 0", err);
    end
`ifdef ASCII_DEC_ERR_CNT_EN
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_err_count: got %0d required 0", err_count);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_basic();
    byte unsigned exp[3] = '{8'd49, 8'd10, 8'd65};
    clear_obs();
    send_line("W 0A 41\r", 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp[k]) begin
        n_fail++;
        $display("FAIL write_cycle%0d: got valid=%0b data=%0d required 1/%0d",
                 k, out_valid, out_data, exp[k]);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL write_in_ready_busy%0d: got %0b required 0", k, in_ready);
      end
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL write_return: got in_ready=%0b out_valid=%0b required 1/0",
               in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 3 || err_seen != 0) begin
      n_fail++;
      $display("FAIL write_total: got %0d bytes %0d errs required 3 bytes 0 errs",
               got_q.size(), err_seen);
    end
  endtask

  task automatic test_read_and_no_space();
    clear_obs();
    send_line("r  0a\n", 1'b0);
    drain();
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'd48 || got_q[1] !== 8'd10 || err_seen != 0) begin
      n_fail++;
      $display("FAIL read_two_spaces: got %0d bytes first=%0d errs=%0d required 48,10 no err",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 0, err_seen);
    end
    clear_obs();
    send_line("R0", 1'b0);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_timing: got err=%0b required 1 the cycle after bad char", err);
    end
    @(posedge clk);
    #1;
    send_line("A\r", 1'b0);
    drain();
    if (exp_cnt < 255) exp_cnt++;
    n_checks++;
    if (got_q.size() != 0 || err_seen != 1) begin
      n_fail++;
      $display("FAIL no_space: got %0d bytes %0d err pulses required 0 bytes 1 pulse",
               got_q.size(), err_seen);
    end
`ifdef ASCII_DEC_ERR_CNT_EN
    n_checks++;
    if (err_count !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL no_space_count: got %0d required %0d", err_count, exp_cnt);
    end
`endif
  endtask

  task automatic test_bad_hex_then_read();
    clear_obs();
    send_line("W 0G 41\r", 1'b0);
    drain();
    if (exp_cnt < 255) exp_cnt++;
    n_checks++;
    if (got_q.size() != 0 || err_seen != 1) begin
      n_fail++;
      $display("FAIL bad_hex: got %0d bytes %0d err pulses required 0 bytes 1 pulse",
               got_q.size(), err_seen);
    end
    clear_obs();
    send_line("R 0A\r", 1'b0);
    drain();
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'd48 || got_q[1] !== 8'd10 || err_seen != 0) begin
      n_fail++;
      $display("FAIL read_after_err: got %0d bytes errs=%0d required 48,10 no err",
               got_q.size(), err_seen);
    end
  endtask

  task automatic test_blank_and_short();
    clear_obs();
    send_line("\r\n   \r", 1'b0);
    drain();
    n_checks++;
    if (got_q.size() != 0 || err_seen != 0) begin
      n_fail++;
      $display("FAIL blank_lines: got %0d bytes %0d errs required none",
               got_q.size(), err_seen);
    end
    clear_obs();
    send_line("W 0A\r", 1'b0);
    drain();
    if (exp_cnt < 255) exp_cnt++;
    n_checks++;
    if (got_q.size() != 0 || err_seen != 1) begin
      n_fail++;
      $display("FAIL short_write: got %0d bytes %0d err pulses required 0 bytes 1 pulse",
               got_q.size(), err_seen);
    end
`ifdef ASCII_DEC_ERR_CNT_EN
    n_checks++;
    if (err_count !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL short_write_count: got %0d required %0d", err_count, exp_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    byte unsigned exp[3] = '{8'd49, 8'd11, 8'd66};
    clear_obs();
    out_ready = 1'b0;
    send_line("W 0B 42\r", 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd49 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: got valid=%0b data=%0d in_ready=%0b required 1/49/0",
                 k, out_valid, out_data, in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    n_checks++;
    if (got_q.size() != 3) begin
      n_fail++; $display("FAIL bp_count: got %0d bytes required 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (got_q[k] !== exp[k]) begin
          n_fail++; $display("FAIL bp_byte%0d: got %0d required %0d", k, got_q[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    clear_obs();
    out_ready = 1'b1;
    send_line("W 0C 43\r", 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_emit: got out_valid=%0b in_ready=%0b required 0/0",
               out_valid, in_ready);
    end
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL pre_reset_bytes: got %0d required 1", got_q.size());
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    clear_obs();
    send_line("R 0C\r", 1'b0);
    drain();
    n_checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'd48 || got_q[1] !== 8'd12 || err_seen != 0) begin
      n_fail++;
      $display("FAIL read_after_reset: got %0d bytes errs=%0d required 48,12 only",
               got_q.size(), err_seen);
    end
`ifdef ASCII_DEC_ERR_CNT_EN
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++; $display("FAIL count_after_reset: got %0d required 0", err_count);
    end
`endif
  endtask

  task automatic test_random();
    string cmds = "RrWw";
    string hexs = "0123456789ABCDEFabcdef";
    string junk = "G x\r0Rz\n";
    clear_obs();
    exp_q.delete();
    exp_err = 0;
    mbuf = "";
    bp_rand = 1'b1;
    for (int ln = 0; ln < 40; ln++) begin
      string l;
      int    k;
      int    m;
      int    pos;
      k = $urandom_range(0, 3);
      l = str1(cmds[k]);
      for (int f = 0; f < ((k >= 2) ? 2 : 1); f++) begin
        repeat ($urandom_range(1, 3)) l = {l, " "};
        l = {l, str1(hexs[$urandom_range(0, 21)]), str1(hexs[$urandom_range(0, 21)])};
      end
      repeat ($urandom_range(0, 2)) l = {l, " "};
      l = {l, ($urandom_range(0, 1) != 0) ? "\r" : "\n"};
      m = $urandom_range(0, 5);
      pos = $urandom_range(1, l.len() - 1);
      if (m == 0) l[0] = junk[$urandom_range(0, junk.len() - 1)];
      else if (m == 1) l[pos] = junk[$urandom_range(0, junk.len() - 1)];
      else if (m == 2) l = {l.substr(0, pos - 1), l.substr(pos + 1, l.len() - 1)};
      send_line(l, 1'b1);
    end
    send_line("\r", 1'b1);
    drain();
    bp_rand = 1'b0;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin
          n_fail++; $display("FAIL rand_byte%0d: got %0d required %0d", k, got_q[k], exp_q[k]);
        end
      end
    end
    n_checks++;
    if (err_seen != exp_err) begin
      n_fail++; $display("FAIL rand_errs: got %0d pulses required %0d", err_seen, exp_err);
    end
`ifdef ASCII_DEC_ERR_CNT_EN
    n_checks++;
    if (err_count !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL rand_err_count: got %0d required %0d", err_count, exp_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_and_no_space();
    test_bad_hex_then_read();
    test_blank_and_short();
    test_backpressure();
    test_reset_mid_emit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
